// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared lengths, state encoding and IO boundary for the memory controller
package mem_ctrl_pkg;
    localparam logic [2:0] LEN_B = 3'b001;
    localparam logic [2:0] LEN_H = 3'b010;
    localparam logic [2:0] LEN_W = 3'b100;
    localparam logic [31:0] IO_BASE = 32'h0003_0000;
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: load/store and instruction-fetch request channels of the memory controller
interface mem_ctrl_if;
    logic        ls_sig;
    logic        load_or_store;
    logic [2:0]  len;
    logic [31:0] ls_addr;
    logic [31:0] store_val;
    logic        ls_done;
    logic [31:0] ls_data;
    logic        if_sig;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    modport master (
        output ls_sig, load_or_store, len, ls_addr, store_val, if_sig, if_addr,
        input  ls_done, ls_data, if_done, if_data
    );
    modport slave (
        input  ls_sig, load_or_store, len, ls_addr, store_val, if_sig, if_addr,
        output ls_done, ls_data, if_done, if_data
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates load/store and fetch requests onto a byte-wide synchronous RAM/IO bus
module mem_ctrl #(
    parameter logic [31:0] IO_BASE = mem_ctrl_pkg::IO_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    mem_ctrl_if.slave   bus,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);
    import mem_ctrl_pkg::*;

    state_t      state, state_n;
    logic [2:0]  cnt, cnt_n, n, n_n, nxt;
    logic [31:0] base, base_n, sdata, sdata_n, acc, acc_n;
    logic [31:0] ls_data_q, ls_data_n, if_data_q, if_data_n, mem_a_n, wr_addr;
    logic        owner_if, owner_n, ls_done_q, ls_done_n, if_done_q, if_done_n;
    logic        mem_wr_n, stall, idle_ok;
    logic [7:0]  mem_dout_n, wr_byte;

    assign bus.ls_done = ls_done_q;
    assign bus.ls_data = ls_data_q;
    assign bus.if_done = if_done_q;
    assign bus.if_data = if_data_q;

    always_comb begin
        nxt        = cnt + 3'd1;
        wr_addr    = state == IDLE ? bus.ls_addr : base + {29'd0, cnt};
        wr_byte    = state == IDLE ? bus.store_val[7:0] : sdata[{cnt[1:0], 3'b000} +: 8];
        stall      = io_buffer_full && wr_addr >= IO_BASE;
        idle_ok    = !ls_done_q && !if_done_q;
        state_n    = state;
        cnt_n      = cnt;
        n_n        = n;
        base_n     = base;
        sdata_n    = sdata;
        acc_n      = acc;
        owner_n    = owner_if;
        ls_data_n  = ls_data_q;
        if_data_n  = if_data_q;
        ls_done_n  = 1'b0;
        if_done_n  = 1'b0;
        mem_a_n    = mem_a;
        mem_dout_n = mem_dout;
        mem_wr_n   = 1'b0;
        case (state)
            IDLE: begin
                if (idle_ok && bus.ls_sig) begin
                    base_n  = bus.ls_addr;
                    n_n     = bus.len;
                    sdata_n = bus.store_val;
                    owner_n = 1'b0;
                    acc_n   = '0;
                    cnt_n   = 3'd0;
                    state_n = bus.load_or_store ? WRITE : READ;
                    if (!bus.load_or_store)
                        mem_a_n = bus.ls_addr;
                    else if (!stall) begin
                        mem_wr_n   = 1'b1;
                        mem_a_n    = wr_addr;
                        mem_dout_n = wr_byte;
                        cnt_n      = 3'd1;
                    end
                end else if (idle_ok && bus.if_sig && !clear) begin
                    base_n  = bus.if_addr;
                    n_n     = LEN_W;
                    owner_n = 1'b1;
                    acc_n   = '0;
                    cnt_n   = 3'd0;
                    state_n = READ;
                    mem_a_n = bus.if_addr;
                end
            end
            READ: begin
                if (owner_if && clear)
                    state_n = IDLE;
                else begin
                    // byte cnt-1 arrives one cycle after its address was issued
                    if (cnt != 3'd0)
                        acc_n = acc | ({24'd0, mem_din} << {cnt - 3'd1, 3'b000});
                    if (cnt == n) begin
                        state_n   = IDLE;
                        ls_done_n = !owner_if;
                        if_done_n = owner_if;
                        if (owner_if)
                            if_data_n = acc_n;
                        else
                            ls_data_n = acc_n;
                    end else begin
                        cnt_n = nxt;
                        if (nxt < n)
                            mem_a_n = base + {29'd0, nxt};
                    end
                end
            end
            WRITE: begin
                if (cnt == n) begin
                    state_n   = IDLE;
                    ls_done_n = 1'b1;
                end else if (!stall) begin
                    mem_wr_n   = 1'b1;
                    mem_a_n    = wr_addr;
                    mem_dout_n = wr_byte;
                    cnt_n      = nxt;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            n         <= '0;
            base      <= '0;
            sdata     <= '0;
            acc       <= '0;
            owner_if  <= 1'b0;
            ls_data_q <= '0;
            if_data_q <= '0;
            ls_done_q <= 1'b0;
            if_done_q <= 1'b0;
            mem_a     <= '0;
            mem_dout  <= '0;
            mem_wr    <= 1'b0;
        end else if (rdy) begin
            state     <= state_n;
            cnt       <= cnt_n;
            n         <= n_n;
            base      <= base_n;
            sdata     <= sdata_n;
            acc       <= acc_n;
            owner_if  <= owner_n;
            ls_data_q <= ls_data_n;
            if_data_q <= if_data_n;
            ls_done_q <= ls_done_n;
            if_done_q <= if_done_n;
            mem_a     <= mem_a_n;
            mem_dout  <= mem_dout_n;
            mem_wr    <= mem_wr_n;
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized and directed checks of mem_ctrl against a byte-addressed shadow memory
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1, clear = 1'b0, io_buffer_full = 1'b0;
    logic [7:0]  mem_din = 8'h00, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    int          total = 0, bad = 0;
    logic [7:0]  ram [logic [31:0]];
    logic [7:0]  model [logic [31:0]];

    mem_ctrl_if bus();

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .bus(bus),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dflt(logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5c;
    endfunction

    function automatic logic [7:0] mget(logic [31:0] a);
        return model.exists(a) ? model[a] : dflt(a);
    endfunction

    // synchronous byte RAM: data for the address of one cycle appears the next
    always @(posedge clk) begin
        mem_din <= ram.exists(mem_a) ? ram[mem_a] : dflt(mem_a);
        if (mem_wr) ram[mem_a] = mem_dout;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic ls_op(input bit st, input logic [2:0] len, input logic [31:0] addr,
                         input logic [31:0] val, input int full);
        logic [31:0] exp, prev;
        logic [31:0] rq[$];
        logic [39:0] wq[$];
        int k, n, lat;
        n = int'(len);
        @(negedge clk);
        prev = bus.ls_data;
        bus.ls_sig = 1'b1;
        bus.load_or_store = st;
        bus.len = len;
        bus.ls_addr = addr;
        bus.store_val = val;
        io_buffer_full = full > 0;
        lat = st ? n + 1 + (addr >= IO_BASE ? full : 0) : n + 2;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
            io_buffer_full = k < full;
            if (!st && k <= n) rq.push_back(mem_a);
            if (mem_wr) wq.push_back({mem_a, mem_dout});
        end while (!bus.ls_done && k < 40);
        bus.ls_sig = 1'b0;
        io_buffer_full = 1'b0;
        chk(st ? "st_lat" : "ld_lat", k, lat);
        if (st) begin
            chk("st_keep", bus.ls_data, prev);
            chk("wr_cnt", wq.size(), n);
            for (int i = 0; i < n; i++) begin
                if (i < wq.size()) begin
                    chk("wr_a", wq[i][39:8], addr + 32'(i));
                    chk("wr_d", {24'd0, wq[i][7:0]}, {24'd0, val[8*i +: 8]});
                end
                model[addr + 32'(i)] = val[8*i +: 8];
            end
        end else begin
            exp = '0;
            for (int i = 0; i < n; i++) begin
                exp[8*i +: 8] = mget(addr + 32'(i));
                chk("rd_a", rq[i], addr + 32'(i));
            end
            chk("ld_data", bus.ls_data, exp);
        end
        @(posedge clk);
    endtask

    task automatic if_op(input logic [31:0] addr);
        logic [31:0] exp;
        int k;
        @(negedge clk);
        bus.if_sig = 1'b1;
        bus.if_addr = addr;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!bus.if_done && k < 40);
        bus.if_sig = 1'b0;
        chk("if_lat", k, 6);
        for (int i = 0; i < 4; i++) exp[8*i +: 8] = mget(addr + 32'(i));
        chk("if_data", bus.if_data, exp);
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] a0, exp, ifd, lsd;
        logic [2:0]  lens [3];
        int k, lk, ik, dcnt, chg;
        lens[0] = LEN_B; lens[1] = LEN_H; lens[2] = LEN_W;
        bus.ls_sig = 1'b0; bus.load_or_store = 1'b0; bus.len = LEN_B;
        bus.ls_addr = '0; bus.store_val = '0; bus.if_sig = 1'b0; bus.if_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 0);
        chk("rst_dout", {24'd0, mem_dout}, 0);
        chk("rst_done", {30'd0, bus.ls_done, bus.if_done}, 0);
        chk("rst_ls_data", bus.ls_data, 0);
        chk("rst_if_data", bus.if_data, 0);
        rst = 1'b0;

        ls_op(1'b1, LEN_W, 32'h100, 32'h4433_2211, 0);
        ls_op(1'b0, LEN_W, 32'h100, 32'h0, 0);
        chk("lw_word", bus.ls_data, 32'h4433_2211);
        ls_op(1'b1, LEN_H, 32'h200, 32'hABCD_1234, 0);
        ls_op(1'b1, LEN_B, 32'h0003_0000, 32'h0000_005A, 3);

        // simultaneous requests: ls first, fetch sampled the cycle after ls_done
        @(negedge clk);
        bus.ls_sig = 1'b1; bus.load_or_store = 1'b0; bus.len = LEN_W; bus.ls_addr = 32'h100;
        bus.if_sig = 1'b1; bus.if_addr = 32'h200;
        k = 0; lk = 0; ik = 0; lsd = '0; ifd = '0;
        do begin
            @(posedge clk); #1;
            k++;
            if (bus.ls_done) begin lk = k; lsd = bus.ls_data; bus.ls_sig = 1'b0; end
            if (bus.if_done) begin ik = k; ifd = bus.if_data; bus.if_sig = 1'b0; end
        end while (ik == 0 && k < 60);
        bus.ls_sig = 1'b0; bus.if_sig = 1'b0;
        chk("pri_ls_lat", lk, 6);
        chk("pri_if_lat", ik, 13);
        chk("pri_ls_data", lsd, 32'h4433_2211);
        for (int i = 0; i < 4; i++) exp[8*i +: 8] = mget(32'h200 + 32'(i));
        chk("pri_if_data", ifd, exp);
        @(posedge clk);

        // fetch aborted by clear in T+2
        @(negedge clk);
        bus.if_sig = 1'b1; bus.if_addr = 32'h140;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1; bus.if_sig = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        a0 = mem_a;
        chk("clr_a", mem_a, 32'h141);
        dcnt = 0; chg = 0;
        for (int i = 0; i < 10; i++) begin
            dcnt += int'(bus.if_done);
            chg += int'(mem_a !== a0 || mem_wr);
            @(negedge clk);
        end
        chk("clr_done", dcnt, 0);
        chk("clr_bus", chg, 0);

        ls_op(1'b0, LEN_B, 32'hFFFF_FFFF, 32'h0, 0);
        ls_op(1'b0, LEN_H, 32'hFFFF_FFFF, 32'h0, 0);
        chk("wrap_hi", {16'd0, bus.ls_data[31:16]}, 0);
        ls_op(1'b1, LEN_W, 32'h0003_0010, 32'hCAFE_F00D, 0);

        // rdy low freezes everything, including arbitration
        @(negedge clk);
        rdy = 1'b0;
        a0 = mem_a;
        bus.ls_sig = 1'b1; bus.load_or_store = 1'b0; bus.len = LEN_B; bus.ls_addr = 32'h180;
        repeat (3) @(negedge clk);
        chk("rdy_hold_a", mem_a, a0);
        chk("rdy_hold_done", {31'd0, bus.ls_done}, 0);
        bus.ls_sig = 1'b0;
        rdy = 1'b1;
        @(negedge clk);

        // reset in the middle of a load word
        bus.ls_sig = 1'b1; bus.load_or_store = 1'b0; bus.len = LEN_W; bus.ls_addr = 32'h120;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.ls_sig = 1'b0;
        chk("mid_rst_a", mem_a, 0);
        chk("mid_rst_data", bus.ls_data, 0);
        chk("mid_rst_done", {31'd0, bus.ls_done}, 0);
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            dcnt += int'(bus.ls_done || bus.if_done || mem_wr);
        end
        chk("mid_rst_quiet", dcnt, 0);

        for (int t = 0; t < 60; t++) begin
            int r, op, full;
            logic [31:0] addr;
            r = $urandom_range(0, 9);
            full = $urandom_range(0, 3);
            addr = r < 6 ? 32'h100 + 32'($urandom_range(0, 63)) :
                   r < 8 ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) :
                           IO_BASE + 32'($urandom_range(0, 255));
            op = $urandom_range(0, 2);
            if (op == 2) if_op(addr);
            else ls_op(op == 1, lens[$urandom_range(0, 2)], addr, $urandom, full);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
